// File: rtl/qpu_ir_queue.sv
// qpu_ir_queue: registered instruction FIFO between the IFU IR stage and EXU dispatch.
// Entries carry {ir, pc, pc_vld, prdt_taken}. A flush discards every buffered entry.
// There is no combinational path from o_ready to i_ready.
module qpu_ir_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [INSTR_W-1:0]       i_ir,
    input  logic [PC_W-1:0]          i_pc,
    input  logic                     i_pc_vld,
    input  logic                     i_prdt_taken,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [INSTR_W-1:0]       o_ir,
    output logic [PC_W-1:0]          o_pc,
    output logic                     o_pc_vld,
    output logic                     o_prdt_taken,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit above the index bits.
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;

    logic [INSTR_W-1:0]   ir_mem_q   [DEPTH];
    logic [PC_W-1:0]      pc_mem_q   [DEPTH];
    logic                 pcv_mem_q  [DEPTH];
    logic                 prdt_mem_q [DEPTH];

    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        rd_idx;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 wr_en;

    // Occupancy flags and handshakes, all derived from registered pointers.
    always_comb begin
        wr_idx  = wr_ptr_q[AW-1:0];
        rd_idx  = rd_ptr_q[AW-1:0];
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count   = wr_ptr_q - rd_ptr_q;
        i_ready = ~full;
        o_valid = ~empty;
        push    = i_valid & i_ready;
        pop     = o_valid & o_ready;
        // A flush cycle cancels both transfers.
        wr_en   = push & ~flush;
    end

    // Next-pointer computation: flush clears, otherwise advance on handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointer registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage: not reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ir_mem_q[wr_idx]   <= i_ir;
            pc_mem_q[wr_idx]   <= i_pc;
            pcv_mem_q[wr_idx]  <= i_pc_vld;
            prdt_mem_q[wr_idx] <= i_prdt_taken;
        end
    end

    // Head entry driven straight from storage, no write-through bypass.
    always_comb begin
        o_ir         = ir_mem_q[rd_idx];
        o_pc         = pc_mem_q[rd_idx];
        o_pc_vld     = pcv_mem_q[rd_idx];
        o_prdt_taken = prdt_mem_q[rd_idx];
    end

    // Overflow/underflow cannot happen given the handshake definitions.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_qpu_ir_queue.sv
// Directed bench for qpu_ir_queue with a scoreboard of expected head entries.
module tb_qpu_ir_queue;

    localparam int DEPTH   = 4;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    logic                clk;
    logic                rst;
    logic                i_valid;
    logic                i_ready;
    logic [INSTR_W-1:0]  i_ir;
    logic [PC_W-1:0]     i_pc;
    logic                i_pc_vld;
    logic                i_prdt_taken;
    logic                o_valid;
    logic                o_ready;
    logic [INSTR_W-1:0]  o_ir;
    logic [PC_W-1:0]     o_pc;
    logic                o_pc_vld;
    logic                o_prdt_taken;
    logic                flush;
    logic [2:0]          count;
    logic                empty;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        pc_vld;
        logic        prdt;
    } ent_t;

    ent_t sb[$];
    int   model_cnt;
    int   total;
    int   passed;

    qpu_ir_queue #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_ir         (i_ir),
        .i_pc         (i_pc),
        .i_pc_vld     (i_pc_vld),
        .i_prdt_taken (i_prdt_taken),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_ir         (o_ir),
        .o_pc         (o_pc),
        .o_pc_vld     (o_pc_vld),
        .o_prdt_taken (o_prdt_taken),
        .flush        (flush),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the occupancy outputs against the bench model.
    task automatic chk_state(input string tag);
        chk({tag, ".count"},   64'(count),   64'(model_cnt));
        chk({tag, ".empty"},   64'(empty),   64'(model_cnt == 0));
        chk({tag, ".o_valid"}, 64'(o_valid), 64'(model_cnt != 0));
        chk({tag, ".i_ready"}, 64'(i_ready), 64'(model_cnt < DEPTH));
    endtask

    // One clock cycle of stimulus; the model decides which handshakes complete.
    task automatic xfer(input string tag, input logic iv, input logic [31:0] ir,
                        input logic [31:0] pc, input logic ordy, input logic fl);
        ent_t e;
        logic push_exp;
        logic pop_exp;
        i_valid      = iv;
        i_ir         = ir;
        i_pc         = pc;
        i_pc_vld     = pc[2];
        i_prdt_taken = pc[3];
        o_ready      = ordy;
        flush        = fl;
        #1;
        push_exp = iv && (model_cnt < DEPTH) && !fl;
        pop_exp  = ordy && (model_cnt > 0) && !fl;
        chk({tag, ".pre_i_ready"}, 64'(i_ready), 64'(model_cnt < DEPTH));
        chk({tag, ".pre_o_valid"}, 64'(o_valid), 64'(model_cnt > 0));
        if (pop_exp) begin
            e = sb.pop_front();
            chk({tag, ".o_ir"},         64'(o_ir),         64'(e.ir));
            chk({tag, ".o_pc"},         64'(o_pc),         64'(e.pc));
            chk({tag, ".o_pc_vld"},     64'(o_pc_vld),     64'(e.pc_vld));
            chk({tag, ".o_prdt_taken"}, 64'(o_prdt_taken), 64'(e.prdt));
        end
        if (push_exp) begin
            e.ir     = ir;
            e.pc     = pc;
            e.pc_vld = pc[2];
            e.prdt   = pc[3];
            sb.push_back(e);
        end
        tick();
        if (fl) begin
            model_cnt = 0;
            sb.delete();
        end else begin
            model_cnt = model_cnt + int'(push_exp) - int'(pop_exp);
        end
        chk_state({tag, ".post"});
    endtask

    initial begin
        total = 0;
        passed = 0;
        model_cnt = 0;
        rst = 1'b1;
        i_valid = 1'b0;
        i_ir = '0;
        i_pc = '0;
        i_pc_vld = 1'b0;
        i_prdt_taken = 1'b0;
        o_ready = 1'b0;
        flush = 1'b0;

        // 1 Reset/idle
        repeat (3) tick();
        chk_state("rst_held");
        rst = 1'b0;
        tick();
        chk_state("rst_idle");

        // 2 Fill with o_ready low, then drain in order
        for (int unsigned k = 0; k < 4; k++) begin
            xfer("fill", 1'b1, 32'hA0 + k, 32'h100 + 4 * k, 1'b0, 1'b0);
        end
        chk("fill.count4", 64'(count), 64'd4);
        chk("fill.i_ready0", 64'(i_ready), 64'd0);
        for (int unsigned k = 0; k < 4; k++) begin
            xfer("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain.empty", 64'(empty), 64'd1);

        // 3 Streaming: 20 instructions with both sides always ready
        for (int unsigned k = 0; k < 20; k++) begin
            xfer("stream", 1'b1, 32'hC00 + k, 4 * k, 1'b1, 1'b0);
            chk("stream.count1", 64'(count), 64'd1);
        end
        xfer("stream_tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 4 Full plus pop: pop happens, push refused
        for (int unsigned k = 0; k < 4; k++) begin
            xfer("refill", 1'b1, 32'hB0 + k, 32'h200 + 4 * k, 1'b0, 1'b0);
        end
        xfer("full_pop", 1'b1, 32'hEE, 32'h300, 1'b1, 1'b0);
        chk("full_pop.count3", 64'(count), 64'd3);

        // 5 Flush with a concurrent push; the flushed push must never surface
        xfer("flush", 1'b1, 32'hFF, 32'h400, 1'b0, 1'b1);
        chk("flush.count0", 64'(count), 64'd0);
        xfer("post_flush", 1'b1, 32'h11, 32'h404, 1'b0, 1'b0);
        chk("post_flush.head", 64'(o_ir), 64'h11);
        xfer("post_flush_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6 Asynchronous reset between edges with two entries queued
        xfer("pre_arst", 1'b1, 32'h21, 32'h500, 1'b0, 1'b0);
        xfer("pre_arst", 1'b1, 32'h22, 32'h504, 1'b0, 1'b0);
        i_valid = 1'b0;
        o_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_cnt = 0;
        sb.delete();
        chk_state("arst_now");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_state("arst_released");
        xfer("after_arst", 1'b1, 32'h33, 32'h600, 1'b0, 1'b0);
        xfer("after_arst_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
